// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an RV32I-subset datapath: sequences fetch/decode/execute,
// drives every datapath control, guards memory waits with a timeout and counts retired instructions.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 and IR/oldPC load on mem_ready
// DECODE   | branch target (oldPC+immB) into ALUOut, dispatch on opcode
// MEMADR   | rd1 + imm (I for lw, S for sw) into ALUOut
// MEMREAD  | data read at ALUOut
// MEMWB    | readData register to rd
// MEMWRITE | data write at ALUOut
// EXECR    | rd1 op rd2
// EXECI    | rd1 op immI
// ALUWB    | ALUOut register to rd
// BEQ      | rd1 - rd2, PC <= ALUOut when zero
// JAL      | PC <= ALUOut (jump target), ALUOut <= oldPC+4
// ERROR    | illegal opcode or memory timeout, absorbing until reset
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       f3,
    input  logic             f7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             regWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUControl,
    output logic [1:0]       inmSrc,
    output logic [1:0]       resSrc,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              mem_state;
    logic              timeout;
    logic              retire;

    logic              mem_req_c, adr_src_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;
    logic [1:0]        alu_src_a_c, alu_src_b_c, inm_src_c, res_src_c;
    logic [2:0]        alu_ctrl_c;

    function automatic logic [2:0] funct_alu(input logic [2:0] fn3, input logic sub_en);
        case (fn3)
            3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            wait_q     <= '0;
            retired_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            retired_q  <= retired_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // A ready on the last allowed wait cycle still completes the access.
    always_comb begin
        mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
        timeout   = mem_state && !mem_ready && (wait_q == WAIT_LAST);
        if (mem_state && !mem_ready && !timeout) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        retire     = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d    = ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                    end
                endcase
            end
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEMWRITE: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            BEQ: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            JAL:      state_d = ALUWB;
            ERROR:    state_d = ERROR;
            default:  state_d = ERROR;
        endcase
        if (timeout) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_comb begin
        mem_req_c   = 1'b0;
        adr_src_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        alu_src_a_c = SRCA_PC;
        alu_src_b_c = SRCB_RD2;
        alu_ctrl_c  = ALU_ADD;
        inm_src_c   = IMM_I;
        res_src_c   = RES_ALUOUT;
        case (state_q)
            FETCH: begin
                mem_req_c   = 1'b1;
                alu_src_a_c = SRCA_PC;
                alu_src_b_c = SRCB_FOUR;
                res_src_c   = RES_ALU;
                ir_write_c  = mem_ready;
                pc_write_c  = mem_ready;
            end
            DECODE: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                inm_src_c   = IMM_B;
            end
            MEMADR: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_IMM;
                inm_src_c   = (op == OP_SW) ? IMM_S : IMM_I;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
            end
            MEMWB: begin
                res_src_c   = RES_RDATA;
                reg_write_c = 1'b1;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = mem_ready;
            end
            EXECR: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_RD2;
                alu_ctrl_c  = funct_alu(f3, op[5] & f7);
            end
            // f7 carries immediate bits here, so an immediate op never subtracts.
            EXECI: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_IMM;
                inm_src_c   = IMM_I;
                alu_ctrl_c  = funct_alu(f3, 1'b0);
            end
            ALUWB: begin
                res_src_c   = RES_ALUOUT;
                reg_write_c = 1'b1;
            end
            BEQ: begin
                alu_src_a_c = SRCA_RD1;
                alu_src_b_c = SRCB_RD2;
                alu_ctrl_c  = ALU_SUB;
                res_src_c   = RES_ALUOUT;
                pc_write_c  = zero;
            end
            JAL: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_FOUR;
                res_src_c   = RES_ALUOUT;
                pc_write_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by rst_n so nothing is written while reset is asserted.
    assign mem_req    = mem_req_c   & rst_n;
    assign memWrite   = mem_write_c & rst_n;
    assign irWrite    = ir_write_c  & rst_n;
    assign pcWrite    = pc_write_c  & rst_n;
    assign regWrite   = reg_write_c & rst_n;
    assign adrSrc     = adr_src_c;
    assign ALUSrcA    = alu_src_a_c;
    assign ALUSrcB    = alu_src_b_c;
    assign ALUControl = alu_ctrl_c;
    assign inmSrc     = inm_src_c;
    assign resSrc     = res_src_c;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle and
// compares the full control word, error state and retired count against hand-derived values.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, adrSrc, memWrite, irWrite, pcWrite, regWrite;
    logic [1:0]  ALUSrcA, ALUSrcB, inmSrc, resSrc;
    logic [2:0]  ALUControl;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;
    int exp_ret = 0;

    logic [16:0] ctl;
    logic [4:0]  en;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .f3(f3), .f7(f7), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .pcWrite(pcWrite), .regWrite(regWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .inmSrc(inmSrc), .resSrc(resSrc),
        .err(err), .err_code(err_code), .retired(retired)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, adrSrc, memWrite, irWrite, pcWrite, regWrite,
                  ALUSrcA, ALUSrcB, ALUControl, inmSrc, resSrc};
    assign en  = {mem_req, memWrite, irWrite, pcWrite, regWrite};

    // Packs an expected control word in the same order as ctl.
    function automatic logic [16:0] cw(input int mr, input int as, input int mw, input int ir,
                                       input int pw, input int rw, input int a, input int b,
                                       input int alu, input int imm, input int res);
        return {1'(mr), 1'(as), 1'(mw), 1'(ir), 1'(pw), 1'(rw),
                2'(a), 2'(b), 3'(alu), 2'(imm), 2'(res)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        #1 chk({tag, "/fetch"}, 32'(ctl), 32'(cw(1,0,0,1,1,0, 0,2,0,0,2)));
        chk({tag, "/fetch_retired"}, retired, 32'(exp_ret));
        nxt();
        #1 chk({tag, "/decode"}, 32'(ctl), 32'(cw(0,0,0,0,0,0, 1,1,0,2,0)));
        nxt();
    endtask

    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] fn3,
                             input logic fn7, input logic [16:0] exp_exec);
        op = o; f3 = fn3; f7 = fn7; zero = 1'b0;
        fetch_decode(tag);
        #1 chk({tag, "/exec"}, 32'(ctl), 32'(exp_exec));
        nxt();
        #1 chk({tag, "/aluwb"}, 32'(ctl), 32'(cw(0,0,0,0,0,1, 0,0,0,0,0)));
        chk({tag, "/aluwb_retired"}, retired, 32'(exp_ret));
        nxt();
        exp_ret++;
    endtask

    task automatic beq_instr(input string tag, input logic z);
        op = OP_BEQ; zero = z;
        fetch_decode(tag);
        #1 chk({tag, "/beq"}, 32'(ctl), 32'(cw(0,0,0,0,int'(z),0, 2,0,1,0,0)));
        nxt();
        exp_ret++;
    endtask

    initial begin
        rst_n = 1'b0; op = OP_R; f3 = 3'b000; f7 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset/enables", 32'(en), 32'd0);
        chk("reset/retired", retired, 32'd0);
        chk("reset/err", 32'(err), 32'd0);
        chk("reset/err_code", 32'(err_code), 32'd0);
        nxt();
        rst_n = 1'b1;

        alu_instr("add",  OP_R, 3'b000, 1'b0, cw(0,0,0,0,0,0, 2,0,0,0,0));
        alu_instr("sub",  OP_R, 3'b000, 1'b1, cw(0,0,0,0,0,0, 2,0,1,0,0));
        alu_instr("addi", OP_I, 3'b000, 1'b1, cw(0,0,0,0,0,0, 2,1,0,0,0));
        alu_instr("or",   OP_R, 3'b110, 1'b0, cw(0,0,0,0,0,0, 2,0,3,0,0));
        alu_instr("slti", OP_I, 3'b010, 1'b0, cw(0,0,0,0,0,0, 2,1,5,0,0));
        alu_instr("and",  OP_R, 3'b111, 1'b0, cw(0,0,0,0,0,0, 2,0,2,0,0));

        beq_instr("beq_taken", 1'b1);
        beq_instr("beq_not", 1'b0);

        op = OP_JAL;
        fetch_decode("jal");
        #1 chk("jal/jal", 32'(ctl), 32'(cw(0,0,0,0,1,0, 1,2,0,0,0)));
        nxt();
        #1 chk("jal/aluwb", 32'(ctl), 32'(cw(0,0,0,0,0,1, 0,0,0,0,0)));
        chk("jal/no_retire_on_jal_edge", retired, 32'(exp_ret));
        nxt();
        exp_ret++;

        op = OP_LW;
        fetch_decode("lw");
        #1 chk("lw/memadr", 32'(ctl), 32'(cw(0,0,0,0,0,0, 2,1,0,0,0)));
        nxt();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("lw/memread_wait", 32'(ctl), 32'(cw(1,1,0,0,0,0, 0,0,0,0,0)));
            nxt();
        end
        mem_ready = 1'b1;
        #1 chk("lw/memread_done", 32'(ctl), 32'(cw(1,1,0,0,0,0, 0,0,0,0,0)));
        chk("lw/no_error_at_last_wait", 32'(err), 32'd0);
        nxt();
        #1 chk("lw/memwb", 32'(ctl), 32'(cw(0,0,0,0,0,1, 0,0,0,0,1)));
        nxt();
        exp_ret++;

        op = OP_SW;
        fetch_decode("sw");
        #1 chk("sw/memadr", 32'(ctl), 32'(cw(0,0,0,0,0,0, 2,1,0,1,0)));
        nxt();
        mem_ready = 1'b0;
        #1 chk("sw/memwrite_wait", 32'(ctl), 32'(cw(1,1,0,0,0,0, 0,0,0,0,0)));
        nxt();
        mem_ready = 1'b1;
        #1 chk("sw/memwrite_done", 32'(ctl), 32'(cw(1,1,1,0,0,0, 0,0,0,0,0)));
        chk("sw/memwrite_retired", retired, 32'(exp_ret));
        nxt();
        exp_ret++;
        #1 chk("sw/retired_after", retired, 32'(exp_ret));

        op = OP_LW;
        fetch_decode("rst_mid");
        nxt();
        mem_ready = 1'b0;
        #1 chk("rst_mid/memread", 32'(ctl), 32'(cw(1,1,0,0,0,0, 0,0,0,0,0)));
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1 chk("rst_mid/ctl", 32'(ctl), 32'(cw(0,0,0,0,0,0, 0,2,0,0,2)));
        chk("rst_mid/retired", retired, 32'd0);
        chk("rst_mid/err", 32'(err), 32'd0);
        nxt();
        chk("rst_mid/enables_held", 32'(en), 32'd0);
        rst_n = 1'b1;
        exp_ret = 0;

        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("timeout/fetch_wait", 32'(ctl), 32'(cw(1,0,0,0,0,0, 0,2,0,0,2)));
            chk("timeout/err_before", 32'(err), 32'd0);
            nxt();
        end
        #1 chk("timeout/error_ctl", 32'(ctl), 32'd0);
        chk("timeout/err", 32'(err), 32'd1);
        chk("timeout/err_code", 32'(err_code), 32'd2);
        mem_ready = 1'b1;
        nxt();
        nxt();
        #1 chk("timeout/held_ctl", 32'(ctl), 32'd0);
        chk("timeout/held_code", 32'(err_code), 32'd2);
        chk("timeout/retired", retired, 32'(exp_ret));
        rst_n = 1'b0;
        #1 chk("timeout/reset_err", 32'(err), 32'd0);
        chk("timeout/reset_code", 32'(err_code), 32'd0);
        nxt();
        rst_n = 1'b1;

        op = 7'b1111111;
        fetch_decode("illegal");
        #1 chk("illegal/error_ctl", 32'(ctl), 32'd0);
        chk("illegal/err", 32'(err), 32'd1);
        chk("illegal/err_code", 32'(err_code), 32'd1);
        nxt();
        #1 chk("illegal/held_code", 32'(err_code), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
